amiq_csv_encoder: RTL and testbench
===================================

// Module: amiq_csv_encoder
// PURPOSE
//  Encodes a stream of binary sample values into a comma-delimited ASCII-decimal byte message,
//  the same wire format the stimulus decoder consumes: "v0,v1,...,vN-1", no trailing delimiter.
//  Sits on the DUT result path; its byte stream feeds the DPI/socket bridge back to the Python server.
// PARAMETERS
//  DATA_W      32  width of each input value (unsigned unless AMIQ_CSV_SIGNED_EN)
//  NOF_VALUES  20  values per message; m_last marks final byte of value NOF_VALUES-1
//  NDIG        derived = ceil(DATA_W*log10(2)), max decimal digits (10 for 32)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  s_valid      in   1        input value valid
//  s_ready      out  1        encoder can accept a value
//  s_data       in   DATA_W   value to encode
//  m_valid      out  1        output byte valid
//  m_ready      in   1        downstream accepts byte
//  m_data       out  8        ASCII byte ('0'-'9', ',', '-')
//  m_last       out  1        final byte of message
//  value_cnt    out  $clog2(NOF_VALUES+1)  values accepted in current message
// BEHAVIOUR
//  Reset: s_ready=0 during rst, 1 the cycle after; m_valid=0, m_data=0, m_last=0, value_cnt=0, state IDLE.
//  Handshakes: transfer on valid&&ready at posedge. m_data/m_last stable while m_valid&&!m_ready.
//  FSM: IDLE -> CONV -> (SIGN) -> DIGITS -> DELIM|IDLE.
//   IDLE: s_ready=1; on s_valid capture s_data, value_cnt++, go CONV. s_ready=0 in all other states.
//   CONV: double-dabble, exactly DATA_W cycles; then SIGN if negative (signed build) else DIGITS.
//   SIGN: emit '-' (8'h2D); advance on m_ready.
//   DIGITS: emit most significant non-zero digit first; leading zeros suppressed; value 0 emits "0".
//   After last digit: if value_cnt<NOF_VALUES go DELIM, else assert m_last on that digit, clear
//   value_cnt, go IDLE. DELIM: emit ',' (8'h2C) then IDLE.
//  Latency: s accept -> first byte m_valid = DATA_W+1 cycles; one byte per cycle with m_ready=1.
//  Boundaries: max value 2^DATA_W-1 emits NDIG digits; NOF_VALUES=1 -> single value, m_last, no ','.
//  m_ready low never drops bytes; rst mid-message discards partial message, no m_last emitted.
//  s_valid while s_ready=0 is held by upstream (no loss); value_cnt wraps only at message end.
// CONFIGURATION
//  AMIQ_CSV_SIGNED_EN defined: s_data is two's complement; negative values emit '-' then |value|
//   (most negative value -2^(DATA_W-1) encodes correctly, magnitude DATA_W bits).
//  Undefined: s_data unsigned; SIGN state and '-' never produced.
// STRUCTURE
//  amiq_csv_pkg: state enum (IDLE,CONV,SIGN,DIGITS,DELIM), ASCII constants DELIM/ZERO/MINUS,
//   function ndig(width) computing NDIG.
//  Sub-module amiq_bin2bcd: iterative double-dabble, start/done, DATA_W-in, NDIG*4-out, own counter.
//  Top holds FSM, digit index/leading-zero tracking, output register, value counter.
// TESTING
//  NOF_VALUES=3, send 5,0,1234, m_ready=1 -> bytes "5,0,1234", m_last only on '4', value_cnt back to 0.
//  Send 32'hFFFF_FFFF -> "4294967295" (10 bytes), no leading zeros.
//  m_ready toggled pseudo-randomly during "1234" -> same byte sequence, data stable while stalled.
//  Assert rst after "12" of 1234 emitted -> m_valid=0 next cycle, next message starts fresh at value 0.
//  AMIQ_CSV_SIGNED_EN, send -7 and 32'h8000_0000 -> "-7" and "-2147483648".
//  Measure s accept to first m_valid -> DATA_W+1 cycles; s_ready=0 until message byte drain done.

Source files
------------

// File: rtl/amiq_csv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amiq_csv_pkg
//  Description : Shared definitions for the CSV encoder: FSM state encoding,
//                ASCII byte constants, digit-count helper and digit-to-ASCII
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package amiq_csv_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_CONV   = 3'd1;
    localparam state_t c_ST_SIGN   = 3'd2;
    localparam state_t c_ST_DIGITS = 3'd3;
    localparam state_t c_ST_DELIM  = 3'd4;

    // ASCII bytes emitted on the output stream
    localparam logic [7:0] c_ASCII_DELIM = 8'h2C;
    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] c_ASCII_MINUS = 8'h2D;

    // ceil(width * log10(2)) using a fixed-point log10(2) = 0.30103
    function automatic int ndig(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    // One BCD nibble to its ASCII character
    function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
        return c_ASCII_ZERO + {4'b0000, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/amiq_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : amiq_bin2bcd
//  Description : Iterative double-dabble binary-to-BCD converter. A start
//                pulse loads the operand; exactly DATA_W shift steps follow,
//                after which done_o rises and stays high until the next start.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                start_i        - load bin_i and begin conversion
//                bin_i          - unsigned binary operand (DATA_W bits)
//                done_o         - conversion complete, bcd_o valid
//                bcd_o          - NDIG packed BCD digits, digit 0 in [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module amiq_bin2bcd #(
    parameter int DATA_W = 32,
    parameter int NDIG   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   bin_i,
    output logic                done_o,
    output logic [NDIG*4-1:0]   bcd_o
);

    localparam int c_BCD_W = NDIG * 4;
    localparam int c_CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]          bin_q;
    logic [c_BCD_W-1:0]         bcd_q;
    logic [c_CNT_W-1:0]         cnt_q;
    logic                       busy_q;
    logic                       done_q;

    logic [c_BCD_W-1:0]         w_bcd_adj;
    logic [c_BCD_W+DATA_W-1:0]  w_shift;

    // Add 3 to every digit >= 5 so the following left shift carries correctly
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        w_shift = {w_bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            bcd_q <= w_shift[c_BCD_W+DATA_W-1:DATA_W];
            bin_q <= w_shift[DATA_W-1:0];
            cnt_q <= cnt_q + c_CNT_W'(1);
            if (cnt_q == c_CNT_W'(DATA_W - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/amiq_csv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : amiq_csv_encoder
//  Description : Encodes a stream of binary values into a comma-delimited
//                ASCII-decimal byte message "v0,v1,...,vN-1". m_last marks
//                the final digit of value NOF_VALUES-1.
//                Build option AMIQ_CSV_SIGNED_EN: treat s_data as two's
//                complement and prefix negative values with '-'.
//  Ports       : clk, rst                  - clock, synchronous active-high reset
//                s_valid/s_ready/s_data    - input value stream
//                m_valid/m_ready/m_data    - output ASCII byte stream
//                m_last                    - final byte of a message
//                value_cnt                 - values accepted in current message
//  Revision    : 1.0 - initial release
// ============================================================================
module amiq_csv_encoder
    import amiq_csv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NOF_VALUES = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [7:0]                        m_data,
    output logic                              m_last,
    output logic [$clog2(NOF_VALUES+1)-1:0]   value_cnt
);

    localparam int c_NDIG  = ndig(DATA_W);
    localparam int c_CNT_W = $clog2(NOF_VALUES + 1);
    localparam int c_IDX_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;

    state_t               state_q,     state_d;
    logic                 s_ready_q,   s_ready_d;
    logic                 m_valid_q,   m_valid_d;
    logic [7:0]           m_data_q,    m_data_d;
    logic                 m_last_q,    m_last_d;
    logic [c_CNT_W-1:0]   value_cnt_q, value_cnt_d;
    logic [c_IDX_W-1:0]   dig_idx_q,   dig_idx_d;
    logic                 neg_q,       neg_d;

    logic                 w_start;
    logic                 w_neg;
    logic [DATA_W-1:0]    w_mag;
    logic                 w_done;
    logic [c_NDIG*4-1:0]  w_bcd;
    logic [c_IDX_W-1:0]   w_first_idx;
    logic [c_IDX_W-1:0]   w_next_idx;
    logic [7:0]           w_first_chr;
    logic [7:0]           w_next_chr;
    logic                 w_take;
    logic                 w_last_val;

`ifdef AMIQ_CSV_SIGNED_EN
    // Magnitude of the most negative value still fits in DATA_W unsigned bits
    assign w_neg = s_data[DATA_W-1];
    assign w_mag = w_neg ? ((~s_data) + DATA_W'(1)) : s_data;
`else
    assign w_neg = 1'b0;
    assign w_mag = s_data;
`endif

    amiq_bin2bcd #(
        .DATA_W (DATA_W),
        .NDIG   (c_NDIG)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (w_start),
        .bin_i   (w_mag),
        .done_o  (w_done),
        .bcd_o   (w_bcd)
    );

    // Most significant non-zero digit; index 0 when the value is zero so a
    // lone "0" is emitted.
    always_comb begin
        w_first_idx = '0;
        for (int i = 0; i < c_NDIG; i++) begin
            if (w_bcd[i*4 +: 4] != 4'd0) begin
                w_first_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_next_idx  = dig_idx_q - c_IDX_W'(1);
    assign w_first_chr = ascii_digit(w_bcd[w_first_idx*4 +: 4]);
    assign w_next_chr  = ascii_digit(w_bcd[w_next_idx*4 +: 4]);
    assign w_take      = m_valid_q && m_ready;
    assign w_last_val  = (value_cnt_q == c_CNT_W'(NOF_VALUES));

    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        value_cnt_d = value_cnt_q;
        dig_idx_d   = dig_idx_q;
        neg_d       = neg_q;
        w_start     = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (s_valid && s_ready_q) begin
                    w_start     = 1'b1;
                    neg_d       = w_neg;
                    value_cnt_d = value_cnt_q + c_CNT_W'(1);
                    state_d     = c_ST_CONV;
                end
            end
            c_ST_CONV: begin
                if (w_done) begin
                    m_valid_d = 1'b1;
                    if (neg_q) begin
                        m_data_d = c_ASCII_MINUS;
                        m_last_d = 1'b0;
                        state_d  = c_ST_SIGN;
                    end else begin
                        m_data_d  = w_first_chr;
                        dig_idx_d = w_first_idx;
                        m_last_d  = (w_first_idx == '0) && w_last_val;
                        state_d   = c_ST_DIGITS;
                    end
                end
            end
            c_ST_SIGN: begin
                if (w_take) begin
                    m_data_d  = w_first_chr;
                    dig_idx_d = w_first_idx;
                    m_last_d  = (w_first_idx == '0) && w_last_val;
                    state_d   = c_ST_DIGITS;
                end
            end
            c_ST_DIGITS: begin
                if (w_take) begin
                    if (dig_idx_q != '0) begin
                        m_data_d  = w_next_chr;
                        dig_idx_d = w_next_idx;
                        m_last_d  = (w_next_idx == '0) && w_last_val;
                    end else if (w_last_val) begin
                        // Final digit of the message just left; start a new message
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        value_cnt_d = '0;
                        state_d     = c_ST_IDLE;
                    end else begin
                        m_data_d = c_ASCII_DELIM;
                        m_last_d = 1'b0;
                        state_d  = c_ST_DELIM;
                    end
                end
            end
            c_ST_DELIM: begin
                if (w_take) begin
                    m_valid_d = 1'b0;
                    state_d   = c_ST_IDLE;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                state_d   = c_ST_IDLE;
            end
        endcase

        // Registered so s_ready is low throughout reset and rises one cycle later
        s_ready_d = (state_d == c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= 8'h00;
            m_last_q    <= 1'b0;
            value_cnt_q <= '0;
            dig_idx_q   <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            value_cnt_q <= value_cnt_d;
            dig_idx_q   <= dig_idx_d;
            neg_q       <= neg_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign value_cnt = value_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_amiq_csv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amiq_csv_encoder
//  Description : Self-checking bench for amiq_csv_encoder (NOF_VALUES=3).
//                Expected bytes are generated from a decimal model into a
//                queue and compared as the encoder emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amiq_csv_encoder;

    localparam int DATA_W = 32;
    localparam int NOF    = 3;
    localparam int CNT_W  = $clog2(NOF + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         m_data;
    logic               m_last;
    logic [CNT_W-1:0]   value_cnt;

    logic [8:0]         exp_q[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 tb_pos = 0;

    amiq_csv_encoder #(
        .DATA_W     (DATA_W),
        .NOF_VALUES (NOF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .value_cnt (value_cnt)
    );

    always #5 clk = ~clk;

    // Decimal model: push expected {last, byte} entries for one value
    task automatic push_value(input logic [31:0] v);
        logic [31:0] mag;
        logic        neg;
        logic [7:0]  digs[$];
        bit          last_val;
`ifdef AMIQ_CSV_SIGNED_EN
        neg = v[31];
`else
        neg = 1'b0;
`endif
        mag = neg ? (~v + 32'd1) : v;
        if (neg) exp_q.push_back({1'b0, 8'h2D});
        if (mag == 0) digs.push_back(8'h30);
        while (mag != 0) begin
            digs.push_front(8'(32'h30 + mag % 10));
            mag = mag / 10;
        end
        tb_pos++;
        last_val = (tb_pos == NOF);
        foreach (digs[i]) exp_q.push_back({last_val && (i == digs.size() - 1), digs[i]});
        if (last_val) tb_pos = 0;
        else exp_q.push_back({1'b0, 8'h2C});
    endtask

    task automatic send_value(input logic [31:0] v);
        int g = 0;
        push_value(v);
        s_data  = v;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Consume bytes until the scoreboard is empty
    task automatic drain(input bit rnd);
        int         g = 0;
        bit         hold_pend = 0;
        logic [8:0] held = '0;
        logic [8:0] exp;
        while (exp_q.size() > 0 && g < 3000) begin
            if (hold_pend) begin
                n_vec++;
                if ({m_valid, m_last, m_data} !== {1'b1, held}) begin
                    n_err++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h", m_valid, {m_last, m_data}, held);
                end
                hold_pend = 0;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid === 1'b1) begin
                n_vec++;
                if (s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL s_ready_busy: got %b required 0", s_ready);
                end
                if (m_ready) begin
                    exp = exp_q.pop_front();
                    n_vec++;
                    if ({m_last, m_data} !== exp) begin
                        n_err++;
                        $display("FAIL byte: got last=%b data=%h required last=%b data=%h",
                                 m_last, m_data, exp[8], exp[7:0]);
                    end
                end else begin
                    held = {m_last, m_data};
                    hold_pend = 1;
                end
            end
            @(posedge clk); #1; g++;
        end
        m_ready = 1'b1;
        n_vec++;
        if (g >= 3000) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes outstanding required 0", exp_q.size());
            exp_q.delete();
        end else if ({m_valid, s_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_end: got m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({s_ready, m_valid, m_data, m_last, value_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h l=%b cnt=%0d required all 0",
                     s_ready, m_valid, m_data, m_last, value_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", s_ready);
        end
    endtask

    task automatic test_basic_message();
        send_value(32'd5);
        n_vec++;
        if (value_cnt !== 1) begin
            n_err++;
            $display("FAIL basic_cnt1: got %0d required 1", value_cnt);
        end
        drain(0);
        send_value(32'd0);
        drain(0);
        send_value(32'd1234);
        drain(0);
        n_vec++;
        if (value_cnt !== 0) begin
            n_err++;
            $display("FAIL basic_cnt_wrap: got %0d required 0", value_cnt);
        end
    endtask

    task automatic test_max_value();
        send_value(32'hFFFF_FFFF); drain(0);
        send_value(32'd0);         drain(0);
        send_value(32'd1);         drain(0);
    endtask

    task automatic test_stall();
        send_value(32'd1234); drain(1);
        send_value(32'd42);   drain(1);
        send_value(32'd1234); drain(1);
    endtask

    task automatic test_latency();
        int lat = 0;
        push_value(32'd99);
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lat_ready: got %b required 1", s_ready);
        end
        s_data = 32'd99; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_vec++;
        if ({s_ready, value_cnt} !== {1'b0, CNT_W'(1)}) begin
            n_err++;
            $display("FAIL lat_accept: got rdy=%b cnt=%0d required 0 1", s_ready, value_cnt);
        end
        do begin
            @(posedge clk); #1; lat++;
        end while (m_valid !== 1'b1 && lat < 100);
        n_vec++;
        if (lat != DATA_W + 1) begin
            n_err++;
            $display("FAIL latency: got %0d cycles required %0d", lat, DATA_W + 1);
        end
        drain(0);
        send_value(32'd1); drain(0);
        send_value(32'd2); drain(0);
    endtask

    task automatic test_reset_mid();
        int         g = 0;
        logic [8:0] exp;
        send_value(32'd1234);
        while (m_valid !== 1'b1 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            n_vec++;
            if ({m_valid, m_last, m_data} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL mid_byte: got v=%b %h required v=1 %h", m_valid, {m_last, m_data}, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({m_valid, m_last, s_ready, value_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b l=%b rdy=%b cnt=%0d required all 0",
                     m_valid, m_last, s_ready, value_cnt);
        end
        rst = 1'b0;
        exp_q.delete();
        tb_pos = 0;
        @(posedge clk); #1;
        send_value(32'd7);
        n_vec++;
        if (value_cnt !== 1) begin
            n_err++;
            $display("FAIL mid_fresh_cnt: got %0d required 1", value_cnt);
        end
        drain(0);
        send_value(32'd8); drain(0);
        send_value(32'd9); drain(0);
    endtask

`ifdef AMIQ_CSV_SIGNED_EN
    task automatic test_signed();
        send_value(-32'sd7);        drain(0);
        send_value(32'h8000_0000);  drain(1);
        send_value(32'd5);          drain(0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_message();
        test_max_value();
        test_stall();
        test_latency();
        test_reset_mid();
`ifdef AMIQ_CSV_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
